// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes for the writeback path.
// The write arbiter and its clients import this package.
package regfile_pkg;

    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts at rr_ptr, and the pointer moves just past
// the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic             found;
    int               cand;

    // The first requester found at or after rr_ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(rr_ptr_q) + k) % N;
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port among NREQ writeback sources.
// It grants one source at a time in round-robin order and drives a registered write stage.
module regfile_write_arbiter #(
    parameter int NREQ      = 3,
    parameter int REG_IDX_W = regfile_pkg::REG_IDX_W,
    parameter int DATA_W    = regfile_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*REG_IDX_W-1:0] req_reg,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      wr_stall,
    output logic                      wr_en,
    output logic [REG_IDX_W-1:0]      wr_reg,
    output logic [DATA_W-1:0]         wr_data,
    output logic [$clog2(NREQ)-1:0]   wr_src
);

    localparam int SRC_W = $clog2(NREQ);

    logic                 free;
    logic                 grant_en;
    logic [NREQ-1:0]      gnt;
    logic [SRC_W-1:0]     gnt_idx;
    logic [REG_IDX_W-1:0] req_reg_arr  [NREQ];
    logic [DATA_W-1:0]    req_data_arr [NREQ];

    logic                 wr_en_q,   wr_en_d;
    logic [REG_IDX_W-1:0] wr_reg_q,  wr_reg_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic [SRC_W-1:0]     wr_src_q,  wr_src_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_reg_arr[i]  = req_reg[i*REG_IDX_W +: REG_IDX_W];
            req_data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // The output slot accepts a new write when it is empty or when its current write retires this cycle.
    assign free     = !wr_en_q || !wr_stall;
    assign grant_en = free && !rst;

    rr_arbiter #(
        .N(NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

    always_comb begin
        wr_en_d   = wr_en_q;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        if (free) begin
            wr_en_d = |gnt;
        end
        if (|gnt) begin
            wr_reg_d  = req_reg_arr[gnt_idx];
            wr_data_d = req_data_arr[gnt_idx];
            wr_src_d  = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_reg  = wr_reg_q;
    assign wr_data = wr_data_q;
    assign wr_src  = wr_src_q;

    // A pending requester must keep its write stable until the arbiter accepts it.
    for (genvar g = 0; g < NREQ; g++) begin : g_hold_chk
        a_req_hold : assert property (@(posedge clk) disable iff (rst)
            (req_valid[g] && !req_ready[g]) |=>
            (req_valid[g]
             && $stable(req_reg[g*REG_IDX_W +: REG_IDX_W])
             && $stable(req_data[g*DATA_W +: DATA_W])));
    end

    a_ready_onehot : assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with NREQ=3, 4-bit register indices and 16-bit data.
// Every expected value below is worked out by hand from the intended behaviour.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*4-1:0]      req_reg;
    logic [NREQ*16-1:0]     req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   wr_stall;
    logic                   wr_en;
    reg_idx_t               wr_reg;
    reg_data_t              wr_data;
    logic [1:0]             wr_src;

    int n_vec = 0;
    int n_err = 0;

    reg_idx_t  exp_reg  [3] = '{4'h1, 4'h2, 4'h3};
    reg_data_t exp_data [3] = '{16'hA0A0, 16'hB0B0, 16'hC0C0};

    regfile_write_arbiter #(
        .NREQ(NREQ), .REG_IDX_W(4), .DATA_W(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_stall  (wr_stall),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .wr_src    (wr_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [3:0] r, input logic [15:0] d);
        chk({tag, "_en"},   32'(wr_en),   32'(en));
        chk({tag, "_reg"},  32'(wr_reg),  32'(r));
        chk({tag, "_data"}, 32'(wr_data), 32'(d));
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] r, input logic [15:0] d);
        req_valid[i]        = v;
        req_reg[i*4 +: 4]   = r;
        req_data[i*16 +: 16] = d;
    endtask

    // Inputs are driven just after the rising edge; outputs are checked at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        wr_stall  = 1'b0;
        req_valid = '0;
        req_reg   = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, exp_reg[i], exp_data[i]);

        // Reset with every requester valid
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk_wr("rst_out", 1'b0, 4'h0, 16'h0);
            chk("rst_src", 32'(wr_src), 32'h0);
            cyc();
        end
        rst = 1'b0;

        // All three continuously valid: grants 0,1,2,0,1,2,...
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
            if (k > 0) begin
                chk_wr("rr_out", 1'b1, exp_reg[(k-1)%3], exp_data[(k-1)%3]);
                chk("rr_src", 32'(wr_src), 32'((k-1) % 3));
            end
            cyc();
            if (k >= 6) req_valid[k-6] = 1'b0;
        end
        @(negedge clk);
        chk("drain_ready", 32'(req_ready), 32'h0);
        chk_wr("drain_out", 1'b1, 4'h3, 16'hC0C0);
        chk("drain_src", 32'(wr_src), 32'd2);
        cyc();
        @(negedge clk);
        chk_wr("idle_hold", 1'b0, 4'h3, 16'hC0C0);

        // Single request; a stall while the slot is empty must not block the grant
        cyc();
        set_req(1, 1'b1, 4'h5, 16'hBEEF);
        wr_stall = 1'b1;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'b010);
        chk("single_pre_en", 32'(wr_en), 32'h0);
        cyc();
        req_valid[1] = 1'b0;
        wr_stall = 1'b0;
        @(negedge clk);
        chk_wr("single_out", 1'b1, 4'h5, 16'hBEEF);
        chk("single_src", 32'(wr_src), 32'd1);
        chk("single_ready0", 32'(req_ready), 32'h0);
        cyc();
        @(negedge clk);
        chk_wr("single_done", 1'b0, 4'h5, 16'hBEEF);

        // A stalled write holds the outputs and blocks every grant
        cyc();
        set_req(2, 1'b1, 4'h3, 16'h3333);
        @(negedge clk);
        chk("stall_pre_ready", 32'(req_ready), 32'b100);
        cyc();
        req_valid[2] = 1'b0;
        set_req(0, 1'b1, 4'h8, 16'h0808);
        wr_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", 32'(req_ready), 32'h0);
            chk_wr("stall_out", 1'b1, 4'h3, 16'h3333);
            chk("stall_src", 32'(wr_src), 32'd2);
            cyc();
        end
        wr_stall = 1'b0;
        @(negedge clk);
        chk("unstall_ready", 32'(req_ready), 32'b001);
        chk_wr("unstall_out", 1'b1, 4'h3, 16'h3333);
        cyc();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk_wr("b2b_out", 1'b1, 4'h8, 16'h0808);
        chk("b2b_src", 32'(wr_src), 32'd0);
        cyc();
        @(negedge clk);
        chk("b2b_done", 32'(wr_en), 32'h0);

        // Two sources write the same register, starting from rr_ptr=0
        cyc();
        set_req(2, 1'b1, 4'h9, 16'h9999);
        @(negedge clk);
        chk("same_pre_ready", 32'(req_ready), 32'b100);
        cyc();
        set_req(0, 1'b1, 4'h7, 16'h1111);
        set_req(2, 1'b1, 4'h7, 16'h2222);
        @(negedge clk);
        chk("same_ready0", 32'(req_ready), 32'b001);
        cyc();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("same_ready2", 32'(req_ready), 32'b100);
        chk_wr("same_first", 1'b1, 4'h7, 16'h1111);
        chk("same_first_src", 32'(wr_src), 32'd0);
        cyc();
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk_wr("same_last", 1'b1, 4'h7, 16'h2222);
        chk("same_last_src", 32'(wr_src), 32'd2);

        // Reset while a write is stalled on the outputs
        cyc();
        set_req(0, 1'b1, 4'hA, 16'hAAAA);
        @(negedge clk);
        chk("mid_pre_ready", 32'(req_ready), 32'b001);
        cyc();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 4'hB, 16'hBBBB);
        wr_stall = 1'b1;
        @(negedge clk);
        chk("mid_stall_ready", 32'(req_ready), 32'h0);
        chk_wr("mid_stall_out", 1'b1, 4'hA, 16'hAAAA);
        cyc();
        rst = 1'b1;
        set_req(0, 1'b1, 4'hC, 16'hCCCC);
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        cyc();
        rst = 1'b0;
        wr_stall = 1'b0;
        @(negedge clk);
        chk_wr("mid_rst_out", 1'b0, 4'h0, 16'h0);
        chk("mid_ptr0_ready", 32'(req_ready), 32'b001);
        cyc();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("mid_ready1", 32'(req_ready), 32'b010);
        chk_wr("mid_re_out0", 1'b1, 4'hC, 16'hCCCC);
        chk("mid_re_src0", 32'(wr_src), 32'd0);
        cyc();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk_wr("mid_re_out1", 1'b1, 4'hB, 16'hBBBB);
        chk("mid_re_src1", 32'(wr_src), 32'd1);
        cyc();
        @(negedge clk);
        chk("mid_done", 32'(wr_en), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
